// File: rtl/video_stream_source_pkg.sv
// rtl/video_stream_source_pkg.sv - shared timing constants, state type and helpers for the pixel stream source
// Purpose: default raster timing, pixel width, source FSM state type and a
// counter-width helper shared by the source and the stream checkers.
// Ports: none (package).
package video_stream_pkg;

  localparam int H_ACTIVE_DEF = 400;
  localparam int H_TOTAL_DEF  = 420;
  localparam int V_ACTIVE_DEF = 300;
  localparam int V_TOTAL_DEF  = 320;
  localparam int PIXEL_W      = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_stream_source_if.sv
// rtl/video_stream_source_if.sv - control, upstream pixel and downstream stream signals of the source
// Purpose: bundles the source's handshake and stream signals.
// Ports (master = source side):
//   in : start, run, pix_in, pix_valid
//   out: pix_ready, dout, blanking_out, validout, frame_done, busy
interface video_stream_source_if
  import video_stream_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_W
);
  logic                  start;
  logic                  run;
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  blanking_out;
  logic                  validout;
  logic                  frame_done;
  logic                  busy;

  modport master (
    input  start, run, pix_in, pix_valid,
    output pix_ready, dout, blanking_out, validout, frame_done, busy
  );

  modport slave (
    output start, run, pix_in, pix_valid,
    input  pix_ready, dout, blanking_out, validout, frame_done, busy
  );
endinterface

// File: rtl/video_stream_source_raster_position_counter.sv
// rtl/video_stream_source_raster_position_counter.sv - column/row raster position tracker
// Purpose: walks col 0..H_TOTAL-1 and row 0..V_TOTAL-1 one beat per advance.
// Ports:
//   i_clock, i_reset (async, active-high), i_advance (step one beat),
//   i_clear (return to col=0,row=0), o_col, o_row,
//   o_active (position is inside the active window), o_last_beat (final beat of frame).
module raster_position_counter
  import video_stream_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  localparam int CW      = cnt_width(H_TOTAL),
  localparam int RW      = cnt_width(V_TOTAL)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_advance,
  input  logic          i_clear,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_active,
  output logic          o_last_beat
);
  localparam logic [CW-1:0] COL_LAST     = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(V_TOTAL - 1);
  // Inclusive bounds so an all-active axis cannot overflow the counter width.
  localparam logic [CW-1:0] COL_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_ACT_LAST = RW'(V_ACTIVE - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col       = r_col;
  assign o_row       = r_row;
  assign o_active    = (r_col <= COL_ACT_LAST) && (r_row <= ROW_ACT_LAST);
  assign o_last_beat = (r_col == COL_LAST) && (r_row == ROW_LAST);
endmodule

// File: rtl/video_stream_source.sv
// rtl/video_stream_source.sv - raster pixel stream source with blanking insertion
// Purpose: pulls active pixels from an upstream valid/ready source and emits a
// registered stream with horizontal/vertical blanking inserted, pausing on
// upstream starvation or when run is low.
// Ports:
//   i_clock, i_reset (async, active-high)
//   io_bus (master): start, run, pix_in, pix_valid in; pix_ready, dout,
//                    blanking_out, validout, frame_done, busy out.
module video_stream_source
  import video_stream_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_W,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_TOTAL    = H_TOTAL_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_TOTAL    = V_TOTAL_DEF,
  parameter int CONTINUOUS = 0
) (
  input logic                   i_clock,
  input logic                   i_reset,
  video_stream_source_if.master io_bus
);
  localparam int CW = cnt_width(H_TOTAL);
  localparam int RW = cnt_width(V_TOTAL);

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_blank;
  logic                  r_valid;
  logic                  r_done;

  logic [CW-1:0]         w_col;
  logic [RW-1:0]         w_row;
  logic                  w_active;
  logic                  w_last_beat;
  logic                  w_streaming;
  logic                  w_advance;
  logic                  w_pos_unused;

  // Blanking beats never wait on the upstream; only active beats need a pixel.
  assign w_streaming = (r_state == STREAM);
  assign w_advance   = w_streaming && io_bus.run && (!w_active || io_bus.pix_valid);

  // Counters are held at the origin while idle so every frame starts at 0,0.
  raster_position_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL)
  ) u_pos (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_advance   (w_advance),
    .i_clear     (!w_streaming),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_active    (w_active),
    .o_last_beat (w_last_beat)
  );

  // Position is only consumed through o_active/o_last_beat here.
  assign w_pos_unused = ^{w_col, w_row};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_state_next = STREAM;
        end
      end
      STREAM: begin
        if (w_advance && w_last_beat && (CONTINUOUS == 0)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_dout  <= '0;
      r_blank <= 1'b1;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (!w_streaming) begin
      r_dout  <= '0;
      r_blank <= 1'b1;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_advance) begin
      r_dout  <= w_active ? io_bus.pix_in : '0;
      r_blank <= !w_active;
      r_valid <= 1'b1;
      r_done  <= w_last_beat;
    end else begin
      // Stall: data and blanking flag hold, only the beat strobe drops.
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end
  end

  assign io_bus.pix_ready    = w_streaming && io_bus.run && w_active;
  assign io_bus.dout         = r_dout;
  assign io_bus.blanking_out = r_blank;
  assign io_bus.validout     = r_valid;
  assign io_bus.frame_done   = r_done;
  assign io_bus.busy         = w_streaming;
endmodule

// File: tb/tb_video_stream_source.sv
// tb/tb_video_stream_source.sv - self-checking bench for video_stream_source
module tb_video_stream_source;
  localparam int HA = 8;
  localparam int HT = 11;
  localparam int VA = 5;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          run = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;

  always #5 clk = ~clk;

  video_stream_source_if #(.DATA_WIDTH(DW)) vif0 ();
  video_stream_source_if #(.DATA_WIDTH(DW)) vif1 ();

  assign vif0.start = start;  assign vif1.start = start;
  assign vif0.run = run;      assign vif1.run = run;
  assign vif0.pix_in = pix_in; assign vif1.pix_in = pix_in;
  assign vif0.pix_valid = pix_valid; assign vif1.pix_valid = pix_valid;

  video_stream_source #(.DATA_WIDTH(DW), .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA),
                        .V_TOTAL(VT), .CONTINUOUS(0))
    dut0 (.i_clock(clk), .i_reset(rst), .io_bus(vif0));
  video_stream_source #(.DATA_WIDTH(DW), .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA),
                        .V_TOTAL(VT), .CONTINUOUS(1))
    dut1 (.i_clock(clk), .i_reset(rst), .io_bus(vif1));

  logic [DW-1:0] o_dout [2];
  logic          o_blank [2];
  logic          o_valid [2];
  logic          o_done [2];
  logic          o_busy [2];
  logic          o_ready [2];
  assign o_dout[0] = vif0.dout;          assign o_dout[1] = vif1.dout;
  assign o_blank[0] = vif0.blanking_out; assign o_blank[1] = vif1.blanking_out;
  assign o_valid[0] = vif0.validout;     assign o_valid[1] = vif1.validout;
  assign o_done[0] = vif0.frame_done;    assign o_done[1] = vif1.frame_done;
  assign o_busy[0] = vif0.busy;          assign o_busy[1] = vif1.busy;
  assign o_ready[0] = vif0.pix_ready;    assign o_ready[1] = vif1.pix_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a flat sequence of FT beats indexed by k.
  bit            m_busy [2];
  int            m_k [2];
  logic [DW-1:0] m_dout [2];
  bit            m_blank [2];
  bit            m_valid [2];
  bit            m_done [2];
  int            n_beats [2];
  int            n_done [2];
  int            n_pix [2];

  function automatic bit is_active(input int k);
    return ((k % HT) < HA) && ((k / HT) < VA);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit act;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 0; m_k[d] = 0; m_dout[d] = '0; m_blank[d] = 1;
        m_valid[d] = 0; m_done[d] = 0;
        n_beats[d] = 0; n_done[d] = 0; n_pix[d] = 0;
      end
      check($sformatf("dout%0d", d), o_dout[d], m_dout[d]);
      check($sformatf("blanking%0d", d), o_blank[d], m_blank[d]);
      check($sformatf("validout%0d", d), o_valid[d], m_valid[d]);
      check($sformatf("frame_done%0d", d), o_done[d], m_done[d]);
      check($sformatf("busy%0d", d), o_busy[d], m_busy[d]);
      check($sformatf("pix_ready%0d", d), o_ready[d], m_busy[d] && run && is_active(m_k[d]));
      if (o_valid[d] === 1'b1) n_beats[d]++;
      if (o_done[d] === 1'b1) begin
        n_done[d]++;
        check($sformatf("beats_per_frame%0d", d), n_beats[d], n_done[d] * FT);
        check($sformatf("pixels_per_frame%0d", d), n_pix[d], n_done[d] * HA * VA);
      end
      if (pix_valid && o_ready[d] === 1'b1) n_pix[d]++;
      if (!rst) begin
        if (!m_busy[d]) begin
          m_valid[d] = 0; m_done[d] = 0; m_dout[d] = '0; m_blank[d] = 1;
          if (start) begin
            m_busy[d] = 1; m_k[d] = 0;
          end
        end else if (run && (!is_active(m_k[d]) || pix_valid)) begin
          act = is_active(m_k[d]);
          m_dout[d]  = act ? pix_in : '0;
          m_blank[d] = !act;
          m_valid[d] = 1;
          m_done[d]  = (m_k[d] == FT - 1);
          if (m_k[d] == FT - 1) begin
            m_k[d] = 0;
            m_busy[d] = (d == 1);
          end else begin
            m_k[d]++;
          end
        end else begin
          m_valid[d] = 0; m_done[d] = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      pix_in = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1; start = 0;
    tick(2);
    rst = 0;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_done(input int d, input int target, input int budget, input string name);
    int c = 0;
    while (n_done[d] < target && c < budget) begin
      tick(1);
      c++;
    end
    check(name, n_done[d], target);
  endtask

  initial begin
    logic [DW-1:0] saved;

    // Model pins for the 11x7 raster with an 8x5 active window.
    check("model_k7_active", is_active(7), 1);
    check("model_k8_hblank", is_active(8), 0);
    check("model_k51_active", is_active(51), 1);
    check("model_k52_hblank", is_active(52), 0);
    check("model_k55_vblank", is_active(55), 0);
    check("model_k76_last", is_active(76), 0);

    tick(2);
    check("reset_dout", vif0.dout, 0);
    check("reset_blank", vif0.blanking_out, 1);
    check("reset_valid", vif0.validout, 0);
    check("reset_done", vif0.frame_done, 0);
    check("reset_busy", vif0.busy, 0);
    rst = 0;
    tick(2);

    // Full frames, upstream always ready; continuous DUT runs two frames.
    run = 1; pix_valid = 1;
    pulse_start();
    wait_done(1, 2, 400, "cont_two_frames");
    tick(3);
    check("full_done_count", n_done[0], 1);
    check("full_beats", n_beats[0], FT);
    check("full_idle_busy", vif0.busy, 0);
    check("full_idle_blank", vif0.blanking_out, 1);
    check("cont_still_busy", vif1.busy, 1);

    // Starvation at an active position (col 3, row 2).
    do_reset();
    run = 1; pix_valid = 1;
    pulse_start();
    tick(25);
    pix_valid = 0;
    tick(1);
    check("starve_valid", vif0.validout, 0);
    tick(4);
    pix_valid = 1;
    saved = pix_in;
    tick(1);
    check("starve_resume_valid", vif0.validout, 1);
    check("starve_resume_dout", vif0.dout, saved);
    wait_done(0, 1, 200, "starve_done");

    // No pixels during vertical blanking: those beats must not wait.
    do_reset();
    run = 1; pix_valid = 1;
    pulse_start();
    tick(55);
    pix_valid = 0;
    wait_done(0, 1, FT - 55 + 2, "vblank_done");
    check("vblank_beats", n_beats[0], FT);

    // run low inside horizontal blanking (col 9, row 1).
    do_reset();
    run = 1; pix_valid = 1;
    pulse_start();
    tick(20);
    run = 0;
    tick(20);
    check("pause_valid", vif0.validout, 0);
    check("pause_ready", vif0.pix_ready, 0);
    run = 1;
    wait_done(0, 1, 200, "pause_done");
    check("pause_beats", n_beats[0], FT);

    // Asynchronous reset mid-frame; start alongside reset is ignored.
    do_reset();
    run = 1; pix_valid = 1;
    pulse_start();
    tick(30);
    rst = 1;
    #1;
    check("async_dout", vif0.dout, 0);
    check("async_blank", vif0.blanking_out, 1);
    check("async_valid", vif0.validout, 0);
    check("async_busy", vif0.busy, 0);
    check("async_ready", vif0.pix_ready, 0);
    start = 1;
    tick(1);
    start = 0; rst = 0;
    tick(1);
    check("start_with_reset_busy", vif0.busy, 0);
    pulse_start();
    wait_done(0, 1, 200, "fresh_frame_done");

    // Randomized traffic with occasional resets and stray start pulses.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      run       = ($urandom % 8) != 0;
      pix_valid = ($urandom % 4) != 0;
      start     = ($urandom % 16) == 0;
      rst       = ($urandom % 1500) == 0;
      tick(1);
    end
    rst = 0; start = 0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_stream_source.md
Name: video_stream_source

Overview:
- Transmit end of the pixel-stream interface consumed by the window and filter blocks: dout / blanking_out / validout.
- Pulls active pixels from an upstream valid/ready pixel source, such as a frame-buffer reader.
- Inserts horizontal and vertical blanking per the fixed raster timing.
- Emits a registered stream with pause (validout=0) on upstream starvation or when run is deasserted.

Parameters:
- DATA_WIDTH, 8, pixel width.
- H_ACTIVE, 400, active pixels per line.
- H_TOTAL, 420, total cycles per line (active + horizontal blanking).
- V_ACTIVE, 300, active lines per frame.
- V_TOTAL, 320, total lines per frame (active + vertical blanking).
- CONTINUOUS, 0: if 1, restart the next frame automatically; if 0, return to IDLE after each frame.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high; all state clears immediately.
- start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise.
- run  in  1  stream enable; 0 pauses the stream (validin analogue for downstream).
- pix_in  in  DATA_WIDTH  upstream pixel.
- pix_valid  in  1  upstream pixel available.
- pix_ready  out  1  combinational: run && state==STREAM && position is active.
- dout  out  DATA_WIDTH  output pixel; 0 during blanking.
- blanking_out  out  1  1 when the emitted position is a blanking position, and in IDLE.
- validout  out  1  1 when dout/blanking_out carry a new stream beat this cycle.
- frame_done  out  1  one-cycle pulse on the cycle the last beat (col=H_TOTAL-1, row=V_TOTAL-1) is emitted.
- busy  out  1  state==STREAM.

Behaviour:
- Reset values: dout=0, blanking_out=1, validout=0, frame_done=0, busy=0, col=0, row=0, state=IDLE.
- States:
  - IDLE -> STREAM on start.
  - STREAM -> IDLE after the last beat if CONTINUOUS=0.
  - If CONTINUOUS=1, STREAM wraps to col=0,row=0 and stays in STREAM.
- Position counters: col runs 0..H_TOTAL-1; row runs 0..V_TOTAL-1. Row increments on col wrap; row wraps to 0 at end of frame.
- Active position: col<H_ACTIVE && row<V_ACTIVE. Every other position is blanking. Example with defaults: stream index i is blanking iff i%420>=400 or i>=126000.
- Advance condition (STREAM): run && (blanking position || pix_valid). When it holds:
  - register dout = active ? pix_in : 0;
  - blanking_out = !active;
  - validout = 1;
  - counters advance.
- Latency: 1 cycle from the accepted pixel (pix_valid && pix_ready) to validout=1 carrying it.
- Stall (STREAM, not advancing):
  - validout=0; counters hold; dout and blanking_out hold last values.
  - Starvation only matters at active positions. Blanking beats never wait on pix_valid.
- run=0 pauses in any position, including blanking. pix_ready=0 while run=0.
- Handshake rule: pix_valid may assert without pix_ready. No pixel is consumed unless both are high on the same cycle. Exactly H_ACTIVE*V_ACTIVE pixels are consumed per frame.
- IDLE: validout=0, blanking_out=1, dout=0, pix_ready=0.
- Simultaneous start in STREAM: ignored. start together with reset: reset wins.
- Reset mid-frame: abandon the frame. No frame_done. Resume only on the next start.
- frame_done asserts only on the advancing cycle of the final beat, not during a stall at that position.

Decomposition:
- Shared package video_stream_pkg:
  - timing constants H_ACTIVE_DEF=400, H_TOTAL_DEF=420, V_ACTIVE_DEF=300, V_TOTAL_DEF=320;
  - PIXEL_W=8;
  - state enum {IDLE, STREAM}.
- One sub-module, raster_position_counter. Inputs: clock, reset, advance, clear. Outputs: col, row, active, last_beat. The same counter is reused by downstream stream checkers.

Test Plan:
- Full frame, pix_valid tied 1, run=1, start pulse:
  - 134400 consecutive beats with validout=1;
  - blanking_out=1 exactly at i%420>=400 or i>=126000;
  - 120000 pixels consumed; dout equals the pixel sequence at latency 1;
  - frame_done at beat 134399; back to IDLE with blanking_out=1.
- Starvation mid-line: drop pix_valid for 50 cycles at col=200, row=10.
  - validout=0 for those cycles; counters hold; the next beat is col 200 with the correct pixel.
- pix_valid=0 throughout vertical blanking (rows 300-319): all 8400 blanking beats still emit with validout=1, dout=0.
- run=0 for 1000 cycles at col=410 (horizontal blanking): no beats, no consumption. Resume at col 410. Total beat count is still 134400.
- CONTINUOUS=1, two frames: no gap between the last beat of frame 0 and beat 0 of frame 1; frame_done pulses twice.
- Async reset at beat 47364: outputs go to reset values immediately with no clock edge. start then yields a fresh frame from col=0,row=0.
